// File: rtl/ball_pad_controller.sv
// Pong game-state engine: steps ball and pads once per frame on the rising edge of vblnk,
// resolves wall/pad bounces and misses, keeps score and sequences serve / game-over.
module ball_pad_controller #(
  parameter int unsigned HOR_PIXELS  = 1024,
  parameter int unsigned VER_PIXELS  = 768,
  parameter int unsigned BALL_SIZE   = 15,
  parameter int unsigned PAD_HEIGHT  = 145,
  parameter int unsigned PAD_WIDTH   = 15,
  parameter int unsigned X_PAD_LEFT  = 30,
  parameter int unsigned X_PAD_RIGHT = 979,
  parameter int unsigned BALL_SPEED  = 4,
  parameter int unsigned PAD_SPEED   = 6,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic       start,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [9:0] y_pad_left,
  output logic [9:0] y_pad_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       point_pulse,
  output logic       game_over
);

  localparam logic [1:0] ST_SERVE  = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_SCORED = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam int unsigned CNT_W = $clog2(SERVE_DELAY);

  localparam logic [9:0] X_CENTRE    = 10'((HOR_PIXELS - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CENTRE    = 10'((VER_PIXELS - BALL_SIZE) / 2);
  localparam logic [9:0] PAD_INIT    = 10'((VER_PIXELS - PAD_HEIGHT) / 2);
  localparam logic [9:0] PAD_MAX     = 10'(VER_PIXELS - 1 - PAD_HEIGHT);
  localparam logic [9:0] Y_BOTTOM    = 10'(VER_PIXELS - 1 - BALL_SIZE);
  localparam logic [9:0] X_RIGHTMOST = 10'(HOR_PIXELS - 1 - BALL_SIZE);
  localparam logic [9:0] X_LEFT_HIT  = 10'(X_PAD_LEFT + PAD_WIDTH + 1);
  localparam logic [9:0] X_RIGHT_HIT = 10'(X_PAD_RIGHT - BALL_SIZE - 1);
  localparam logic [9:0] B_STEP      = 10'(BALL_SPEED);
  localparam logic [9:0] P_STEP      = 10'(PAD_SPEED);

  // Comparisons are done one bit wider so sums near 1023 and differences near 0 cannot wrap.
  localparam logic [10:0] W_BALL   = 11'(BALL_SIZE);
  localparam logic [10:0] W_PAD_H  = 11'(PAD_HEIGHT);
  localparam logic [10:0] W_BSTEP  = 11'(BALL_SPEED);
  localparam logic [10:0] W_PSTEP  = 11'(PAD_SPEED);
  localparam logic [10:0] W_PADMAX = 11'(VER_PIXELS - 1 - PAD_HEIGHT);
  localparam logic [10:0] W_YMAX   = 11'(VER_PIXELS - 1);
  localparam logic [10:0] W_XMAX   = 11'(HOR_PIXELS - 1);
  localparam logic [10:0] W_LFACE  = 11'(X_PAD_LEFT + PAD_WIDTH);
  localparam logic [10:0] W_RFACE  = 11'(X_PAD_RIGHT);

  localparam logic [3:0]       SCORE_MAX  = 4'(MAX_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

  logic [1:0]       state_q, state_d;
  logic             vblnk_q;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [9:0]       pl_q, pl_d, pr_q, pr_d;
  logic [3:0]       sl_q, sl_d, sr_q, sr_d;
  logic             dx_q, dx_d;   // 1 = moving right
  logic             dy_q, dy_d;   // 1 = moving down
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             go_q, go_d;
  logic             lscored_q, lscored_d;

  logic        tick;
  logic [10:0] x_w, y_w, pl_w, pr_w;
  logic        overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic down);
    logic [10:0] y_w1;
    logic [9:0]  y_n;
    y_w1 = {1'b0, y};
    y_n  = y;
    if (up && !down) begin
      y_n = (y_w1 < W_PSTEP) ? '0 : y - P_STEP;
    end else if (down && !up) begin
      y_n = (y_w1 + W_PSTEP > W_PADMAX) ? PAD_MAX : y + P_STEP;
    end
    return y_n;
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction

  assign tick = vblnk & ~vblnk_q;

  assign x_w  = {1'b0, x_q};
  assign y_w  = {1'b0, y_q};
  assign pl_w = {1'b0, pl_q};
  assign pr_w = {1'b0, pr_q};

  // Collision tests see the pad positions from before this tick's pad move.
  assign overlap_l = (y_w + W_BALL >= pl_w) && (y_w <= pl_w + W_PAD_H);
  assign overlap_r = (y_w + W_BALL >= pr_w) && (y_w <= pr_w + W_PAD_H);
  assign hit_l  = !dx_q && (x_w >= W_LFACE) && (x_w - W_BSTEP <= W_LFACE) && overlap_l;
  assign hit_r  = dx_q && (x_w + W_BALL < W_RFACE) && (x_w + W_BALL + W_BSTEP >= W_RFACE) && overlap_r;
  assign miss_l = !dx_q && (x_w < W_BSTEP);
  assign miss_r = dx_q && (x_w + W_BALL + W_BSTEP > W_XMAX);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pl_d      = pl_q;
    pr_d      = pr_q;
    sl_d      = sl_q;
    sr_d      = sr_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    go_d      = go_q;
    lscored_d = lscored_q;

    if (tick) begin
      pl_d = pad_step(pl_q, left_up, left_down);
      pr_d = pad_step(pr_q, right_up, right_down);
    end

    case (state_q)
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (tick) begin
          if (!dy_q && (y_w < W_BSTEP)) begin
            y_d  = '0;
            dy_d = 1'b1;
          end else if (dy_q && (y_w + W_BALL + W_BSTEP > W_YMAX)) begin
            y_d  = Y_BOTTOM;
            dy_d = 1'b0;
          end else begin
            y_d = dy_q ? y_q + B_STEP : y_q - B_STEP;
          end

          if (hit_l) begin
            x_d  = X_LEFT_HIT;
            dx_d = 1'b1;
          end else if (hit_r) begin
            x_d  = X_RIGHT_HIT;
            dx_d = 1'b0;
          end else if (miss_l) begin
            x_d       = '0;
            lscored_d = 1'b0;
            state_d   = ST_SCORED;
          end else if (miss_r) begin
            x_d       = X_RIGHTMOST;
            lscored_d = 1'b1;
            state_d   = ST_SCORED;
          end else begin
            x_d = dx_q ? x_q + B_STEP : x_q - B_STEP;
          end
        end
      end

      ST_SCORED: begin
        // Lasts exactly one clock; the next serve heads toward the player who conceded.
        pulse_d = 1'b1;
        x_d     = X_CENTRE;
        y_d     = Y_CENTRE;
        dx_d    = lscored_q;
        if (lscored_q) begin
          sl_d = score_inc(sl_q);
        end else begin
          sr_d = score_inc(sr_q);
        end
        if ((lscored_q ? score_inc(sl_q) : score_inc(sr_q)) == SCORE_MAX) begin
          state_d = ST_OVER;
          go_d    = 1'b1;
        end else begin
          state_d = ST_SERVE;
        end
      end

      ST_OVER: begin
        x_d = X_CENTRE;
        y_d = Y_CENTRE;
        if (tick && start) begin
          sl_d    = '0;
          sr_d    = '0;
          go_d    = 1'b0;
          state_d = ST_SERVE;
        end
      end

      default: state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SERVE;
      vblnk_q   <= 1'b0;
      x_q       <= X_CENTRE;
      y_q       <= Y_CENTRE;
      pl_q      <= PAD_INIT;
      pr_q      <= PAD_INIT;
      sl_q      <= '0;
      sr_q      <= '0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      go_q      <= 1'b0;
      lscored_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vblnk_q   <= vblnk;
      x_q       <= x_d;
      y_q       <= y_d;
      pl_q      <= pl_d;
      pr_q      <= pr_d;
      sl_q      <= sl_d;
      sr_q      <= sr_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      go_q      <= go_d;
      lscored_q <= lscored_d;
    end
  end

  assign x_ball      = x_q;
  assign y_ball      = y_q;
  assign y_pad_left  = pl_q;
  assign y_pad_right = pr_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign point_pulse = pulse_q;
  assign game_over   = go_q;

endmodule

// File: tb/tb_ball_pad_controller.sv
// Bench for ball_pad_controller: a frame-level game model checked against the DUT every cycle,
// plus literal expectations at known points of a directed game.
module tb_ball_pad_controller;

  logic       clk = 1'b0;
  logic       rst, vblnk, lu, ld, ru, rd, start;
  logic [9:0] x_ball, y_ball, ypl, ypr;
  logic [3:0] sl, sr;
  logic       pp, go;

  always #5 clk = ~clk;

  ball_pad_controller dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .left_up(lu), .left_down(ld), .right_up(ru), .right_down(rd), .start(start),
    .x_ball(x_ball), .y_ball(y_ball), .y_pad_left(ypl), .y_pad_right(ypr),
    .score_left(sl), .score_right(sr), .point_pulse(pp), .game_over(go)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model (frame level, signed directions) ----------------
  localparam int PH_SERVE = 0, PH_PLAY = 1, PH_SCORED = 2, PH_OVER = 3;
  int m_x, m_y, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_ph;
  bit m_vq, m_pp, m_go, m_left_scored, ev_lhit, ev_rhit;
  int n_lhit = 0, n_rhit = 0;

  function automatic int pad_move(input int p, input logic up, input logic dn);
    if (up && !dn) return (p - 6 < 0) ? 0 : p - 6;
    if (dn && !up) return (p + 6 > 622) ? 622 : p + 6;
    return p;
  endfunction

  always @(posedge clk) begin
    bit tk, ovl, ovr;
    int nx, ny, npl, npr;
    ev_lhit = 0;
    ev_rhit = 0;
    if (rst) begin
      m_x = 504; m_y = 376; m_dx = 1; m_dy = 1; m_pl = 311; m_pr = 311;
      m_sl = 0; m_sr = 0; m_cnt = 0; m_ph = PH_SERVE; m_vq = 0; m_pp = 0; m_go = 0;
    end else begin
      tk   = vblnk && !m_vq;
      m_vq = vblnk;
      m_pp = 0;
      if (m_ph == PH_SCORED) begin
        m_pp = 1; m_x = 504; m_y = 376;
        if (m_left_scored) begin
          m_sl = (m_sl >= 9) ? 9 : m_sl + 1; m_dx = 1;
          if (m_sl == 9) m_ph = PH_OVER; else m_ph = PH_SERVE;
        end else begin
          m_sr = (m_sr >= 9) ? 9 : m_sr + 1; m_dx = -1;
          if (m_sr == 9) m_ph = PH_OVER; else m_ph = PH_SERVE;
        end
        if (m_ph == PH_OVER) m_go = 1;
      end else if (tk) begin
        npl = pad_move(m_pl, lu, ld);
        npr = pad_move(m_pr, ru, rd);
        if (m_ph == PH_SERVE) begin
          m_cnt++;
          if (m_cnt == 60) begin m_cnt = 0; m_ph = PH_PLAY; end
        end else if (m_ph == PH_PLAY) begin
          if (m_dy < 0 && m_y < 4) begin ny = 0; m_dy = 1; end
          else if (m_dy > 0 && m_y + 19 > 767) begin ny = 752; m_dy = -1; end
          else ny = m_y + 4 * m_dy;
          ovl = (m_y + 15 >= m_pl) && (m_y <= m_pl + 145);
          ovr = (m_y + 15 >= m_pr) && (m_y <= m_pr + 145);
          if (m_dx < 0 && m_x >= 45 && m_x - 4 <= 45 && ovl) begin
            nx = 46; m_dx = 1; ev_lhit = 1; n_lhit++;
          end else if (m_dx > 0 && m_x + 15 < 979 && m_x + 19 >= 979 && ovr) begin
            nx = 963; m_dx = -1; ev_rhit = 1; n_rhit++;
          end else if (m_dx < 0 && m_x < 4) begin
            nx = 0; m_left_scored = 0; m_ph = PH_SCORED;
          end else if (m_dx > 0 && m_x + 19 > 1023) begin
            nx = 1008; m_left_scored = 1; m_ph = PH_SCORED;
          end else nx = m_x + 4 * m_dx;
          m_x = nx; m_y = ny;
        end else if (start) begin
          m_sl = 0; m_sr = 0; m_go = 0; m_ph = PH_SERVE;
        end
        m_pl = npl; m_pr = npr;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int pulse_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("x_ball", x_ball, m_x);
      chk("y_ball", y_ball, m_y);
      chk("y_pad_left", ypl, m_pl);
      chk("y_pad_right", ypr, m_pr);
      chk("score_left", sl, m_sl);
      chk("score_right", sr, m_sr);
      chk("point_pulse", pp, m_pp);
      chk("game_over", go, m_go);
      if (ev_lhit) chk("left_hit_x", x_ball, 46);
      if (ev_rhit) chk("right_hit_x", x_ball, 963);
      if (pp === 1'b1) pulse_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  // pad modes: 0 idle, 1 up, 2 down, 3 both, 4 follow ball, 5 keep away from ball
  int lmode = 0, rmode = 0;

  task automatic pad_btn(input int mode, input int pad, output logic up, output logic dn);
    int tgt;
    tgt = m_y + 7 - 72;
    up = 0; dn = 0;
    case (mode)
      1: up = 1;
      2: dn = 1;
      3: begin up = 1; dn = 1; end
      4: begin if (pad < tgt - 3) dn = 1; else if (pad > tgt + 3) up = 1; end
      5: begin if (m_y < 376) dn = 1; else up = 1; end
      default: ;
    endcase
  endtask

  // One frame: vblnk high for two cycles then low for two; returns on a negedge.
  task automatic frame();
    logic a, b;
    pad_btn(lmode, m_pl, a, b); lu = a; ld = b;
    pad_btn(rmode, m_pr, a, b); ru = a; rd = b;
    vblnk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_x"}, x_ball, 504);
    chk({tag, "_y"}, y_ball, 376);
    chk({tag, "_pl"}, ypl, 311);
    chk({tag, "_pr"}, ypr, 311);
    chk({tag, "_sl"}, sl, 0);
    chk({tag, "_sr"}, sr, 0);
    chk({tag, "_pulse"}, pp, 0);
    chk({tag, "_go"}, go, 0);
  endtask

  initial begin
    int base;
    rst = 1; vblnk = 0; lu = 0; ld = 0; ru = 0; rd = 0; start = 0;
    repeat (2) @(negedge clk);
    chk_reset_values("rst");
    cmp_en = 1;
    rst = 0;

    // Serve hold, then first moves and the bottom-wall bounce.
    repeat (60) frame();
    chk("serve_hold_x", x_ball, 504);
    chk("serve_hold_y", y_ball, 376);
    frame();
    chk("play1_x", x_ball, 508);
    chk("play1_y", y_ball, 380);
    frame();
    chk("play2_x", x_ball, 512);
    repeat (91) frame();
    chk("wall_pre_y", y_ball, 748);
    chk("wall_pre_x", x_ball, 876);
    frame();
    chk("wall_step_y", y_ball, 752);
    frame();
    chk("wall_bounce_y", y_ball, 752);
    frame();
    chk("wall_after_y", y_ball, 748);
    chk("wall_after_x", x_ball, 888);

    // Right pad idle at 311 cannot reach the ball near y=676: right misses.
    repeat (31) frame();
    chk("miss_r_sl", sl, 1);
    chk("miss_r_x", x_ball, 504);
    chk("miss_r_y", y_ball, 376);
    chk("miss_r_pulses", pulse_cnt, 1);

    // Pad clamping and both-buttons hold.
    lmode = 1;
    repeat (60) frame();
    chk("pad_top", ypl, 0);
    lmode = 3;
    repeat (5) frame();
    chk("pad_both", ypl, 0);
    lmode = 2;
    repeat (104) frame();
    chk("pad_bottom", ypl, 622);
    lmode = 0;

    // Reset in the middle of play.
    rst = 1;
    @(negedge clk);
    chk_reset_values("midrst");
    rst = 0;

    // Rally: both pads follow, then the left pad steps away and the left side misses.
    lmode = 4; rmode = 4;
    for (int i = 0; i < 800 && n_lhit == 0; i++) frame();
    lmode = 5;
    base = pulse_cnt;
    for (int i = 0; i < 1500 && m_sr == 0; i++) frame();
    chk("miss_l_sr", sr, 1);
    chk("miss_l_sl", sl, 0);
    chk("miss_l_pulses", pulse_cnt - base, 1);

    // Left keeps returning, right keeps dodging, until left reaches the winning score.
    lmode = 4; rmode = 5;
    for (int i = 0; i < 4000 && !m_go; i++) frame();
    chk("over_sl", sl, 9);
    chk("over_sr", sr, 1);
    chk("over_go", go, 1);
    chk("over_x", x_ball, 504);
    chk("over_y", y_ball, 376);
    lmode = 0; rmode = 0;
    repeat (3) frame();
    chk("over_hold_go", go, 1);
    chk("over_hold_sl", sl, 9);
    start = 1;
    frame();
    start = 0;
    chk("restart_sl", sl, 0);
    chk("restart_sr", sr, 0);
    chk("restart_go", go, 0);
    repeat (60) frame();
    chk("restart_hold_x", x_ball, 504);
    frame();
    chk("restart_play_x", x_ball, 508);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
